// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the parametrised shift-and-add multiplier.
package seq_mul_pkg;

  // Controller states: accept operands, iterate, apply sign, hold result.
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } state_e;

  // Widest operand the magnitude helper can handle.
  localparam int unsigned MaxW = 64;

  // Magnitude of the low w bits of x; x is taken as two's complement only when sgn is set.
  function automatic logic [MaxW-1:0] abs_w(input logic [MaxW-1:0] x,
                                            input int unsigned   w,
                                            input logic          sgn);
    logic [MaxW-1:0] mask;
    logic            msb;
    mask = (w >= MaxW) ? '1 : ((MaxW'(1) << w) - MaxW'(1));
    msb  = |((x >> (w - 1)) & MaxW'(1));
    if (sgn && msb) begin
      abs_w = (~x + MaxW'(1)) & mask;
    end else begin
      abs_w = x & mask;
    end
  endfunction

endpackage

// File: rtl/seq_mul_step.sv
// One iteration of the shift-and-add multiplier: retire STEP multiplier bits.
module seq_mul_step
  import seq_mul_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter int unsigned STEP = 1
) (
  input  logic [2*W-1:0]  i_acc,
  input  logic [STEP-1:0] i_b_lsbs,
  input  logic [W-1:0]    i_a_mag,
  output logic [2*W-1:0]  o_acc_next
);

  localparam int unsigned AccW = 2 * W + STEP;
  localparam int unsigned PW   = 2 * W;

  logic [AccW-1:0] w_pp;

  // The sum is formed at 2W+STEP bits; after k iterations it holds |a| * (low k*STEP bits
  // of |b|) << (W - k*STEP), which is always below 2^(2W), so the top STEP bits are zero.
  always_comb begin
    w_pp       = AccW'(i_b_lsbs) * AccW'(i_a_mag);
    o_acc_next = PW'((AccW'(i_acc) >> STEP) + (w_pp << (W - STEP)));
  end

endmodule

// File: rtl/seq_mul_param.sv
// Iterative W x W multiplier, unsigned or two's complement per operation, STEP bits per cycle.
module seq_mul_param
  import seq_mul_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter int unsigned STEP = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           sgn,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  localparam int unsigned N    = W / STEP;
  localparam int unsigned CntW = $clog2(N + 1);
  localparam int unsigned PW   = 2 * W;

  state_e          r_state;
  state_e          w_next_state;
  logic [W-1:0]    r_a_mag;
  logic [W-1:0]    r_b;
  logic            r_neg;
  logic [PW-1:0]   r_acc;
  logic [CntW-1:0] r_cnt;
  logic [PW-1:0]   r_p;
  logic            r_out_valid;

  logic [W-1:0]    w_a_mag;
  logic [W-1:0]    w_b_mag;
  logic [PW-1:0]   w_acc_next;
  logic            w_last;

  assign w_a_mag = W'(abs_w(MaxW'(a), W, sgn));
  assign w_b_mag = W'(abs_w(MaxW'(b), W, sgn));
  // The edge that performs the N-th iteration leaves RUN.
  assign w_last  = (r_cnt == CntW'(N - 1));

  seq_mul_step #(
    .W   (W),
    .STEP(STEP)
  ) u_step (
    .i_acc     (r_acc),
    .i_b_lsbs  (r_b[STEP-1:0]),
    .i_a_mag   (r_a_mag),
    .o_acc_next(w_acc_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      StIdle:  if (in_valid) w_next_state = StRun;
      StRun:   if (w_last) w_next_state = StFix;
      StFix:   w_next_state = StDone;
      StDone:  if (out_ready) w_next_state = StIdle;
      default: w_next_state = StIdle;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    in_ready = (r_state == StIdle);
    busy     = (r_state == StRun) || (r_state == StFix);
  end

  // Operand capture, iteration, sign fix-up and result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_mag     <= '0;
      r_b         <= '0;
      r_neg       <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_p         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a_mag <= w_a_mag;
            r_b     <= w_b_mag;
            r_neg   <= sgn & (a[W-1] ^ b[W-1]);
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        StRun: begin
          r_acc <= w_acc_next;
          r_b   <= r_b >> STEP;
          r_cnt <= r_cnt + CntW'(1);
        end
        StFix: begin
          r_p         <= r_neg ? (PW'(0) - r_acc) : r_acc;
          r_out_valid <= 1'b1;
        end
        StDone: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign p         = r_p;

endmodule

// File: tb/tb_seq_mul_param.sv
// Bench for seq_mul_param: three configurations (8/1, 8/2, 16/4) share one stimulus stream
// and are checked every cycle against a cycle-count/arithmetic model.
module tb_seq_mul_param;

  localparam int NI = 3;

  int wi  [NI] = '{8, 8, 16};
  int nit [NI] = '{8, 4, 4};

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        sgn_in;
  logic [15:0] a_in;
  logic [15:0] b_in;

  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic        bsy0, bsy1, bsy2;
  logic [15:0] p0, p1;
  logic [31:0] p2;

  logic [NI-1:0] rdy_v;
  logic [NI-1:0] ov_v;
  logic [NI-1:0] bsy_v;
  logic [31:0]   dp [NI];

  assign rdy_v = {rdy2, rdy1, rdy0};
  assign ov_v  = {ov2, ov1, ov0};
  assign bsy_v = {bsy2, bsy1, bsy0};
  assign dp[0] = {16'h0, p0};
  assign dp[1] = {16'h0, p1};
  assign dp[2] = p2;

  seq_mul_param #(.W(8), .STEP(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .a(a_in[7:0]),
    .b(b_in[7:0]), .sgn(sgn_in), .out_valid(ov0), .out_ready(out_ready), .p(p0), .busy(bsy0)
  );
  seq_mul_param #(.W(8), .STEP(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .a(a_in[7:0]),
    .b(b_in[7:0]), .sgn(sgn_in), .out_valid(ov1), .out_ready(out_ready), .p(p1), .busy(bsy1)
  );
  seq_mul_param #(.W(16), .STEP(4)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .a(a_in),
    .b(b_in), .sgn(sgn_in), .out_valid(ov2), .out_ready(out_ready), .p(p2), .busy(bsy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Plain arithmetic product of the low w bits, truncated to 2w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic s);
    longint mask, va, vb, prod;
    mask = (longint'(1) << w) - 1;
    va   = longint'(a) & mask;
    vb   = longint'(b) & mask;
    if (s && va >= (longint'(1) << (w - 1))) va = va - (longint'(1) << w);
    if (s && vb >= (longint'(1) << (w - 1))) vb = vb - (longint'(1) << w);
    prod = va * vb;
    return 64'(prod & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Model: 0 = waiting for operands, 1 = computing for N+1 edges, 2 = holding result.
  int          m_st   [NI];
  int          m_left [NI];
  logic        m_ov   [NI];
  logic [63:0] m_p    [NI];
  logic [63:0] m_prod [NI];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_st[i]   <= 0;
        m_left[i] <= 0;
        m_ov[i]   <= 1'b0;
        m_p[i]    <= '0;
      end else begin
        case (m_st[i])
          0: if (in_valid) begin
            m_st[i]   <= 1;
            m_left[i] <= nit[i] + 1;
            m_prod[i] <= ref_mul(wi[i], a_in, b_in, sgn_in);
          end
          1: begin
            m_left[i] <= m_left[i] - 1;
            if (m_left[i] == 1) begin
              m_st[i] <= 2;
              m_ov[i] <= 1'b1;
              m_p[i]  <= m_prod[i];
            end
          end
          default: if (out_ready) begin
            m_st[i] <= 0;
            m_ov[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  // Every-cycle comparison of all outputs of all instances.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("in_ready[%0d]", i), 64'(rdy_v[i]), 64'(m_st[i] == 0));
        chk($sformatf("busy[%0d]", i), 64'(bsy_v[i]), 64'(m_st[i] == 1));
        chk($sformatf("out_valid[%0d]", i), 64'(ov_v[i]), 64'(m_ov[i]));
        chk($sformatf("p[%0d]", i), 64'(dp[i]), m_p[i]);
      end
    end
  end

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFF80;
      2:       return 16'h0080;
      3:       return 16'hFFFF;
      4:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // One transaction with out_ready high: checks latency and product of every instance.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [15:0] e8, input logic [31:0] e16);
    int seen [NI];
    a_in     = a;
    b_in     = b;
    sgn_in   = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a_in     = 16'($urandom);
    b_in     = 16'($urandom);
    sgn_in   = ~s;
    for (int i = 0; i < NI; i++) seen[i] = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (seen[i] == 0 && ov_v[i]) begin
          seen[i] = c;
          chk($sformatf("latency[%0d]", i), 64'(c), 64'(nit[i] + 1));
          chk($sformatf("p_lit[%0d] %h*%h", i, a, b), 64'(dp[i]),
              (i < 2) ? 64'(e8) : 64'(e16));
        end
      end
    end
    for (int i = 0; i < NI; i++) chk($sformatf("out_valid_seen[%0d]", i), 64'(seen[i] != 0), 64'd1);
  endtask

  logic [15:0] tv_a  [6] = '{16'h00FE, 16'hFF80, 16'hFFFF, 16'hFF80, 16'h0000, 16'hFFFF};
  logic [15:0] tv_b  [6] = '{16'h00FE, 16'hFF80, 16'h0001, 16'h007F, 16'hFFFB, 16'hFFFF};
  logic        tv_s  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [15:0] tv_e8 [6] = '{16'hFC04, 16'h4000, 16'hFFFF, 16'hC080, 16'h0000, 16'hFE01};
  logic [31:0] tv_e16[6] = '{32'h0000FC04, 32'h00004000, 32'hFFFFFFFF, 32'hFFFFC080,
                             32'h00000000, 32'hFFFE0001};

  initial begin
    int t_first [NI];
    int t_second[NI];
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sgn_in    = 1'b0;
    a_in      = '0;
    b_in      = '0;

    // Pin the reference model to hand-computed products.
    chk("ref 8u FE*FE", ref_mul(8, 16'h00FE, 16'h00FE, 1'b0), 64'hFC04);
    chk("ref 8s -128*127", ref_mul(8, 16'h0080, 16'h007F, 1'b1), 64'hC080);
    chk("ref 8s -128*-128", ref_mul(8, 16'h0080, 16'h0080, 1'b1), 64'h4000);
    chk("ref 16u FFFF*FFFF", ref_mul(16, 16'hFFFF, 16'hFFFF, 1'b0), 64'hFFFE0001);

    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst in_ready[%0d]", i), 64'(rdy_v[i]), 64'd1);
      chk($sformatf("rst out_valid[%0d]", i), 64'(ov_v[i]), 64'd0);
      chk($sformatf("rst busy[%0d]", i), 64'(bsy_v[i]), 64'd0);
      chk($sformatf("rst p[%0d]", i), 64'(dp[i]), 64'd0);
    end
    rst    = 1'b0;
    chk_en = 1'b1;

    // Directed unsigned and signed corner products.
    for (int t = 0; t < 6; t++) do_op(tv_a[t], tv_b[t], tv_s[t], tv_e8[t], tv_e16[t]);

    // Back-pressure: result held, new requests ignored while DONE.
    out_ready = 1'b0;
    a_in      = 16'h0007;
    b_in      = 16'h0009;
    sgn_in    = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      a_in     = 16'h0011;
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("bp out_valid[%0d]", i), 64'(ov_v[i]), 64'd1);
        chk($sformatf("bp in_ready[%0d]", i), 64'(rdy_v[i]), 64'd0);
        chk($sformatf("bp p[%0d]", i), 64'(dp[i]), 64'd63);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("bp release out_valid[%0d]", i), 64'(ov_v[i]), 64'd0);
      chk($sformatf("bp release p[%0d]", i), 64'(dp[i]), 64'd63);
    end

    // Reset in the middle of RUN.
    a_in     = 16'h00C3;
    b_in     = 16'h005A;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("midrst in_ready[%0d]", i), 64'(rdy_v[i]), 64'd1);
      chk($sformatf("midrst out_valid[%0d]", i), 64'(ov_v[i]), 64'd0);
      chk($sformatf("midrst busy[%0d]", i), 64'(bsy_v[i]), 64'd0);
      chk($sformatf("midrst p[%0d]", i), 64'(dp[i]), 64'd0);
    end
    rst = 1'b0;
    do_op(16'h0003, 16'h0005, 1'b0, 16'd15, 32'd15);

    // Back-to-back accepts: initiation interval N+3 with in_valid and out_ready held.
    for (int i = 0; i < NI; i++) begin
      t_first[i]  = -1;
      t_second[i] = -1;
    end
    a_in     = 16'h0123;
    b_in     = 16'h0F0F;
    in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (rdy_v[i]) begin
          if (t_first[i] < 0) t_first[i] = c;
          else if (t_second[i] < 0) t_second[i] = c;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int i = 0; i < NI; i++)
      chk($sformatf("II[%0d]", i), 64'(t_second[i] - t_first[i]), 64'(nit[i] + 3));
    repeat (14) @(negedge clk);

    // Random traffic with corner-biased operands and occasional resets.
    for (int c = 0; c < 20000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sgn_in    = 1'($urandom_range(0, 1));
      a_in      = pick();
      b_in      = pick();
      rst       = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
